// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the processor data port. A level-held read or
// write request is accepted from IDLE, serviced from an internal word array
// after a fixed latency, and acknowledged with a one-cycle MEM_READY pulse.
// MEM_ERR accompanies READY for conflicting or out-of-range requests.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      MEM_ADDR,
    input  logic [31:0]      MEM_WDATA,
    input  logic             MEM_WEN,
    input  logic             MEM_REN,
    output logic [31:0]      MEM_RDATA,
    output logic             MEM_READY,
    output logic             MEM_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] RD_CNT,
    output logic [CNT_W-1:0] WR_CNT
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_wen;
    logic              r_ren;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic              r_err;
    logic [CNT_W-1:0]  r_rdCnt;
    logic [CNT_W-1:0]  r_wrCnt;
    logic [31:0]       r_mem [DEPTH];

    logic              w_reqAny;
    logic              w_service;
    logic              w_conflict;
    logic              w_inRange;
    logic              w_doWrite;
    logic [AW-1:0]     w_index;

    assign w_reqAny   = MEM_WEN | MEM_REN;
    assign w_service  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_conflict = r_wen & r_ren;
    // Full 32-bit compare so aliasing high addresses are rejected
    assign w_inRange  = (r_addr < 32'(DEPTH));
    assign w_index    = r_addr[AW-1:0];
    assign w_doWrite  = w_service & r_wen & ~r_ren & w_inRange & ~rst;

    assign MEM_RDATA = r_rdata;
    assign MEM_READY = r_ready;
    assign MEM_ERR   = r_err;
    assign BUSY      = (r_state != S_IDLE);
    assign RD_CNT    = r_rdCnt;
    assign WR_CNT    = r_wrCnt;

    // Word array write port; contents survive reset and a reset on the service edge drops the write
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    // Request FSM: accept, count down latency, respond for one cycle, then wait for the request to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdCnt <= '0;
            r_wrCnt <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_reqAny) begin
                        r_addr  <= MEM_ADDR;
                        r_wdata <= MEM_WDATA;
                        r_wen   <= MEM_WEN;
                        r_ren   <= MEM_REN;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        if (w_conflict || !w_inRange) begin
                            r_err <= 1'b1;
                        end else if (r_wen) begin
                            if (r_wrCnt != '1) begin
                                r_wrCnt <= r_wrCnt + 1'b1;
                            end
                        end else begin
                            r_rdata <= r_mem[w_index];
                            if (r_rdCnt != '1) begin
                                r_rdCnt <= r_rdCnt + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= w_reqAny ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (!w_reqAny) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Transaction-level bench: each request is driven and held like a real
// initiator, and the response is compared with a reference model kept as a
// plain array plus counters, updated once per completed transaction.
module tb_data_mem_responder;

    localparam int DEPTH  = 64;
    localparam int LAT    = 3;
    localparam int CW     = 6;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   memAddr;
    logic [31:0]   memWdata;
    logic          memWen;
    logic          memRen;
    logic [31:0]   memRdata;
    logic          memReady;
    logic          memErr;
    logic          busy;
    logic [CW-1:0] rdCnt;
    logic [CW-1:0] wrCnt;

    int            numVectors = 0;
    int            numMiscompares = 0;

    logic [31:0]   refMem [DEPTH];
    logic [31:0]   refRdata;
    int            refRd;
    int            refWr;

    // Free-running clock
    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_ADDR  (memAddr),
        .MEM_WDATA (memWdata),
        .MEM_WEN   (memWen),
        .MEM_REN   (memRen),
        .MEM_RDATA (memRdata),
        .MEM_READY (memReady),
        .MEM_ERR   (memErr),
        .BUSY      (busy),
        .RD_CNT    (rdCnt),
        .WR_CNT    (wrCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        refRdata = 32'd0;
        refRd    = 0;
        refWr    = 0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst    = 1'b1;
        memWen = 1'b0;
        memRen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "Ready"}, 32'(memReady), 32'd0);
        checkOutput({tag, "Err"},   32'(memErr),   32'd0);
        checkOutput({tag, "Busy"},  32'(busy),     32'd0);
        checkOutput({tag, "Rdata"}, memRdata,      refRdata);
        checkOutput({tag, "RdCnt"}, 32'(rdCnt),    32'(refRd));
        checkOutput({tag, "WrCnt"}, 32'(wrCnt),    32'(refWr));
    endtask

    // One complete initiator transaction, optionally aborted by reset while waiting
    task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int holdExtra, input bit abortWithReset);
        int   edges;
        bit   seen;
        logic expErr;
        @(negedge clk);
        memWen   = we;
        memRen   = re;
        memAddr  = addr;
        memWdata = wdata;
        @(posedge clk);
        #1;
        checkOutput("busyAfterAccept", 32'(busy), 32'd1);
        checkOutput("readyAtAccept", 32'(memReady), 32'd0);
        @(negedge clk);
        memAddr  = $urandom;
        memWdata = $urandom;
        if (abortWithReset) begin
            rst    = 1'b1;
            memWen = 1'b0;
            memRen = 1'b0;
            @(posedge clk);
            #1;
            @(negedge clk);
            rst = 1'b0;
            resetModel();
            seen = 1'b0;
            for (int i = 0; i < LAT + 2; i++) begin
                @(posedge clk);
                #1;
                if (memReady) seen = 1'b1;
            end
            checkOutput("readyAfterAbort", 32'(seen), 32'd0);
            checkQuiet("abort");
            return;
        end
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < LAT + 6) begin
            @(posedge clk);
            #1;
            edges++;
            seen = memReady;
        end
        if (!seen) begin
            checkOutput("readyTimeout", 32'd0, 32'd1);
            resetDut();
            return;
        end
        checkOutput("latency", 32'(edges), 32'(LAT));
        expErr = (we && re) || (addr >= 32'(DEPTH));
        if (!expErr) begin
            if (we) begin
                refMem[addr] = wdata;
                if (refWr < CNTMAX) refWr++;
            end else begin
                refRdata = refMem[addr];
                if (refRd < CNTMAX) refRd++;
            end
        end
        checkOutput("err",   32'(memErr), 32'(expErr));
        checkOutput("rdata", memRdata,    refRdata);
        checkOutput("rdCnt", 32'(rdCnt),  32'(refRd));
        checkOutput("wrCnt", 32'(wrCnt),  32'(refWr));
        for (int i = 0; i < holdExtra; i++) begin
            @(posedge clk);
            #1;
            checkOutput("holdReady", 32'(memReady), 32'd0);
            checkOutput("holdBusy",  32'(busy),     32'd1);
        end
        @(negedge clk);
        memWen = 1'b0;
        memRen = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("releaseBusy",  32'(busy),     32'd0);
        checkOutput("releaseReady", 32'(memReady), 32'd0);
    endtask

    // Directed scenarios followed by a randomized transaction stream
    initial begin
        logic        we;
        logic        re;
        logic [31:0] addr;
        int          op;
        rst      = 1'b1;
        memWen   = 1'b0;
        memRen   = 1'b0;
        memAddr  = 32'd0;
        memWdata = 32'd0;
        resetModel();
        resetDut();
        #1;
        checkQuiet("reset");

        applyStimulus(1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i), $urandom, 0, 1'b0);
        end

        applyStimulus(1'b1, 1'b0, 32'd64, 32'hCAFEF00D, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'd2, 32'h55AA55AA, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h8000_0003, 32'h11111111, 1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd2, 32'd0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd3, 32'd0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd3, 32'd0, 10, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'd7, 32'h00001234, 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd7, 32'd0, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd64, 32'd0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            we = (op <= 4);
            re = (op == 0) || (op >= 5);
            if ($urandom_range(0, 3) == 0) begin
                addr = ($urandom_range(0, 1) == 0) ? 32'(DEPTH + $urandom_range(0, 100))
                                                   : ($urandom | 32'h8000_0000);
            end else begin
                addr = 32'($urandom_range(0, DEPTH - 1));
            end
            applyStimulus(we, re, addr, $urandom, $urandom_range(0, 3),
                          (n < 120) && ($urandom_range(0, 29) == 0));
        end

        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b0, 1'b1, 32'($urandom_range(0, DEPTH - 1)), 32'd0, 0, 1'b0);
            applyStimulus(1'b1, 1'b0, 32'($urandom_range(0, DEPTH - 1)), $urandom, 0, 1'b0);
        end
        checkOutput("rdSaturated", 32'(rdCnt), 32'(CNTMAX));
        checkOutput("wrSaturated", 32'(wrCnt), 32'(CNTMAX));

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
